// File: rtl/hdlbc_pkg.sv
// Shared definitions for the iterative HDLBC core: default widths,
// FSM state encoding and the round-constant generator.
package hdlbc_pkg;

    localparam int DEF_BLOCK_W = 64;
    localparam int DEF_KEY_W   = 64;
    localparam int DEF_ROUNDS  = 25;
    localparam int DEF_CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [63:0] RC_BASE = 64'h9E37_79B9_7F4A_7C15;

    // Round constant table: RC_BASE rotated left by the round index, with the
    // index folded into the low bits so no two rounds share a constant.
    function automatic logic [63:0] round_const(input logic [63:0] idx);
        logic [5:0] sh;
        sh = idx[5:0];
        return ((RC_BASE << sh) | (RC_BASE >> (7'd64 - {1'b0, sh}))) ^ idx;
    endfunction

endpackage

// File: rtl/hdlbc_iter_core_if.sv
// Handshake bundle for hdlbc_iter_core: plaintext/key in, ciphertext out.
// Macro HDLBC_DYN_ROUNDS_EN adds the per-block round-count field rounds_i.
interface hdlbc_iter_core_if
    import hdlbc_pkg::*;
#(
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int KEY_W   = DEF_KEY_W,
    parameter int CNT_W   = DEF_CNT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] state;
    logic [KEY_W-1:0]   keys;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] result;
    logic               busy;
`ifdef HDLBC_DYN_ROUNDS_EN
    logic [CNT_W-1:0]   rounds_i;

    modport master (output in_valid, state, keys, rounds_i, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, state, keys, rounds_i, out_ready,
                    output in_ready, out_valid, result, busy);
`else
    modport master (output in_valid, state, keys, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, state, keys, out_ready,
                    output in_ready, out_valid, result, busy);
`endif
endinterface

// File: rtl/hdlbc_round.sv
// One combinational HDLBC round: key whitening, rotate, add round constant,
// diffuse; the key schedule rotates the key and folds in the round index.
module hdlbc_round
    import hdlbc_pkg::*;
#(
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int KEY_W   = DEF_KEY_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    output logic [BLOCK_W-1:0] next_state,
    output logic [KEY_W-1:0]   next_key,
    input  logic [BLOCK_W-1:0] cur_state,
    input  logic [KEY_W-1:0]   cur_key,
    input  logic [CNT_W-1:0]   round_idx
);

    function automatic logic [BLOCK_W-1:0] rotl_b(input logic [BLOCK_W-1:0] x, input int n);
        return (x << n) | (x >> (BLOCK_W - n));
    endfunction

    function automatic logic [KEY_W-1:0] rotl_k(input logic [KEY_W-1:0] x, input int n);
        return (x << n) | (x >> (KEY_W - n));
    endfunction

    logic [BLOCK_W-1:0] kx_s;
    logic [BLOCK_W-1:0] rc_s;
    logic [BLOCK_W-1:0] t_s;
    logic [63:0]        rc64_s;

    // Round datapath; key and constant are stretched to the block width by bit reuse.
    always_comb begin
        kx_s   = {BLOCK_W{1'b0}};
        rc_s   = {BLOCK_W{1'b0}};
        rc64_s = round_const(64'(round_idx));
        for (int i = 0; i < BLOCK_W; i++) begin
            kx_s[i] = cur_key[i % KEY_W];
            rc_s[i] = rc64_s[i % 64];
        end
        t_s        = rotl_b(cur_state ^ kx_s, 7) + rc_s;
        next_state = t_s ^ rotl_b(t_s, BLOCK_W - 17);
        next_key   = rotl_k(cur_key, 13) ^ KEY_W'(round_idx);
    end

endmodule

// File: rtl/hdlbc_iter_core.sv
// Iterative HDLBC encryption core, one round per clock, valid/ready on both
// sides. Macro HDLBC_DYN_ROUNDS_EN enables a per-block round count (rounds_i).
module hdlbc_iter_core
    import hdlbc_pkg::*;
#(
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int KEY_W   = DEF_KEY_W,
    parameter int ROUNDS  = DEF_ROUNDS,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    hdlbc_iter_core_if.slave bus
);

    fsm_t               fsm_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   last_r;
    logic [BLOCK_W-1:0] res_r;
    logic [KEY_W-1:0]   key_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [BLOCK_W-1:0] nxt_res_s;
    logic [KEY_W-1:0]   nxt_key_s;
    logic [CNT_W-1:0]   eff_last_s;
    logic               in_ready_s;
    logic               accept_s;

    hdlbc_round #(
        .BLOCK_W (BLOCK_W),
        .KEY_W   (KEY_W),
        .CNT_W   (CNT_W)
    ) u_round (
        .next_state (nxt_res_s),
        .next_key   (nxt_key_s),
        .cur_state  (res_r),
        .cur_key    (key_r),
        .round_idx  (cnt_r)
    );

`ifdef HDLBC_DYN_ROUNDS_EN
    // Index of the final round for the offered block; 0 or oversize means full ROUNDS.
    always_comb begin
        if ((bus.rounds_i == {CNT_W{1'b0}}) || (bus.rounds_i > CNT_W'(ROUNDS))) begin
            eff_last_s = CNT_W'(ROUNDS - 1);
        end else begin
            eff_last_s = bus.rounds_i - CNT_W'(1);
        end
    end
`else
    assign eff_last_s = CNT_W'(ROUNDS - 1);
`endif

    // A new block may enter when idle or in the very cycle the result is taken.
    assign in_ready_s = (fsm_r == IDLE) || ((fsm_r == DONE) && bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.result    = res_r;

    // Control FSM with round counter, datapath registers and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r       <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            last_r      <= CNT_W'(ROUNDS - 1);
            res_r       <= {BLOCK_W{1'b0}};
            key_r       <= {KEY_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept_s) begin
            fsm_r       <= RUN;
            cnt_r       <= {CNT_W{1'b0}};
            last_r      <= eff_last_s;
            res_r       <= bus.state;
            key_r       <= bus.keys;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            case (fsm_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                RUN: begin
                    res_r <= nxt_res_s;
                    key_r <= nxt_key_s;
                    if (cnt_r == last_r) begin
                        // Counter stops on the last index so it never wraps.
                        fsm_r       <= DONE;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm_r       <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    fsm_r       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdlbc_iter_core.sv
// Self-checking bench for hdlbc_iter_core with a behavioural cipher model.
module tb_hdlbc_iter_core;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    hdlbc_iter_core_if bus ();

    hdlbc_iter_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (plain 64-bit arithmetic) -------------
    function automatic logic [63:0] rol(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] model(input logic [63:0] p, input logic [63:0] k, input int n);
        logic [63:0] s;
        logic [63:0] kk;
        logic [63:0] t;
        logic [63:0] rc;
        s  = p;
        kk = k;
        for (int r = 0; r < n; r++) begin
            rc = rol(64'h9E37_79B9_7F4A_7C15, r) ^ 64'(r);
            t  = rol(s ^ kk, 7) + rc;
            s  = t ^ ror(t, 17);
            kk = rol(kk, 13) ^ 64'(r);
        end
        return s;
    endfunction

    // ---------------- checking ----------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Offer one block, measure latency, check the result, optionally stall the sink.
    task automatic run_block(input string tag, input logic [63:0] p, input logic [63:0] k,
                             input int nr, input int exp_lat, input int stall);
        int guard;
        int acc;
        logic [63:0] exp_res;
        exp_res      = model(p, k, nr);
        bus.state    = p;
        bus.keys     = k;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            step();
            guard++;
        end
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        acc          = cyc;
        bus.in_valid = 1'b0;
        bus.state    = rnd64();
        check({tag, "_busy"}, 64'(bus.busy), (exp_lat > 1) ? 64'd1 : 64'd0);
        guard = 0;
        while (!bus.out_valid && guard < 200) begin
            step();
            guard++;
        end
        check({tag, "_latency"}, 64'(cyc - acc), 64'(exp_lat));
        check({tag, "_result"}, bus.result, exp_res);
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                step();
                check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
                check({tag, "_hold_result"}, bus.result, exp_res);
                check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            end
            bus.out_ready = 1'b1;
            #1;
            check({tag, "_take_in_ready"}, 64'(bus.in_ready), 64'd1);
        end
        step();
        check({tag, "_released"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_idle_result"}, bus.result, exp_res);
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        logic [63:0] vp [4];
        logic [63:0] vk [4];
        int          acc [4];
        int          guard;
        int          t4_acc;
        int          pulses;
        logic [63:0] p;
        logic [63:0] k;

        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.state     = 64'h0;
        bus.keys      = 64'h0;
        bus.out_ready = 1'b1;
`ifdef HDLBC_DYN_ROUNDS_EN
        bus.rounds_i  = 5'd0;
`endif
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single zero block with a 10-cycle sink stall.
        run_block("t1", 64'h0, 64'h0, 25, 25, 10);

        // Back-to-back: in_valid held across four blocks.
        for (int v = 0; v < 4; v++) begin
            vp[v] = rnd64();
            vk[v] = rnd64();
        end
        for (int v = 0; v < 4; v++) begin
            bus.state    = vp[v];
            bus.keys     = vk[v];
            bus.in_valid = 1'b1;
            guard = 0;
            while (!bus.in_ready && guard < 100) begin
                step();
                guard++;
            end
            check("t3_in_ready", 64'(bus.in_ready), 64'd1);
            if (v > 0) begin
                check("t3_out_valid", 64'(bus.out_valid), 64'd1);
                check("t3_result", bus.result, model(vp[v-1], vk[v-1], 25));
            end
            step();
            acc[v] = cyc;
            if (v > 0) begin
                check("t3_period", 64'(acc[v] - acc[v-1]), 64'd26);
            end
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            step();
            guard++;
        end
        check("t3_last_latency", 64'(cyc - acc[3]), 64'd25);
        check("t3_last_result", bus.result, model(vp[3], vk[3], 25));
        step();

        // Offers made while running are ignored.
        p = rnd64();
        k = rnd64();
        bus.state    = p;
        bus.keys     = k;
        bus.in_valid = 1'b1;
        step();
        t4_acc       = cyc;
        bus.state    = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            step();
            guard++;
        end
        check("t4_latency", 64'(cyc - t4_acc), 64'd25);
        check("t4_result", bus.result, model(p, k, 25));
        step();

        // Reset in the middle of a block.
        bus.state    = rnd64();
        bus.keys     = rnd64();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        check("t5_result", bus.result, 64'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.out_valid) pulses++;
        end
        check("t5_no_pulse", 64'(pulses), 64'd0);
        run_block("t5_next", rnd64(), rnd64(), 25, 25, 0);

        // Random blocks with random sink stalls.
        for (int i = 0; i < 6; i++) begin
            run_block("rand", rnd64(), rnd64(), 25, 25, int'($urandom_range(0, 3)));
        end

`ifdef HDLBC_DYN_ROUNDS_EN
        bus.rounds_i = 5'd1;
        run_block("t6_r1", rnd64(), rnd64(), 1, 1, 1);
        bus.rounds_i = 5'd0;
        run_block("t6_r0", rnd64(), rnd64(), 25, 25, 0);
        bus.rounds_i = 5'd31;
        run_block("t6_r31", rnd64(), rnd64(), 25, 25, 2);
        bus.rounds_i = 5'd7;
        run_block("t6_r7", rnd64(), rnd64(), 7, 7, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
